// File: rtl/parking_ctrl_pkg.sv
// parking_ctrl_pkg: lane indices, arbiter states, timer width and round-robin pick shared by the gate arbiter
package parking_ctrl_pkg;
  localparam int NUM_LANES = 4;
  localparam logic [1:0] LANE_ENTRY0 = 2'd0;
  localparam logic [1:0] LANE_ENTRY1 = 2'd1;
  localparam logic [1:0] LANE_EXIT0 = 2'd2;
  localparam logic [1:0] LANE_EXIT1 = 2'd3;
  localparam int TIMER_W = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_CHECK} arb_state_t;
  function automatic logic [1:0] rr_pick(input logic [NUM_LANES-1:0] elig, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/gate_timer.sv
// gate_timer: per-lane barrier hold-open down-counter, loaded on accept and saturating at zero
module gate_timer
  import parking_ctrl_pkg::*;
#(
  parameter int OPEN_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic open
);
  logic [TIMER_W-1:0] count;
  always_ff @(posedge clock) begin
    count <= !reset ? '0 : load ? TIMER_W'(OPEN_CYCLES) : count - TIMER_W'(count != '0);
  end
  assign open = count != '0;
endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares the Parking event port between two entry and two exit lanes.
// Defining EXIT_PRIORITY_EN makes eligible exits win over entries.
module parking_gate_arbiter
  import parking_ctrl_pkg::*;
#(
  parameter int OPEN_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] entry_req,
  input  logic [1:0] entry_is_uni,
  input  logic [1:0] exit_req,
  input  logic [1:0] exit_is_uni,
  output logic [1:0] entry_ack,
  output logic [1:0] entry_reject,
  output logic [1:0] exit_ack,
  output logic [1:0] exit_reject,
  output logic [3:0] gate_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  input  logic       uni_is_vacated_space,
  input  logic       free_is_vacated_space,
  input  logic       faulty_exit
);
  arb_state_t state, state_nx;
  logic [1:0] lane, rr_ptr, win;
  logic cls, vac, is_exit, issue, check;
  logic [NUM_LANES-1:0] elig, pick_set, cls_in, sel, load;
  assign cls_in = {exit_is_uni, entry_is_uni};
  assign elig = {exit_req, entry_req} & ~gate_open;
`ifdef EXIT_PRIORITY_EN
  assign pick_set = |elig[3:2] ? {elig[3:2], 2'b00} : elig;
`else
  assign pick_set = elig;
`endif
  assign win = rr_pick(pick_set, rr_ptr);
  assign is_exit = lane >= LANE_EXIT0;
  assign vac = cls ? uni_is_vacated_space : free_is_vacated_space;
  assign issue = state == ARB_ISSUE;
  assign check = state == ARB_CHECK;
  assign sel = 4'b1 << lane;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ARB_IDLE;
      lane <= '0;
      cls <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && |pick_set) begin
        lane <= win;
        cls <= cls_in[win];
        rr_ptr <= win + 2'd1;
      end
    end
  end
  always_comb begin
    state_nx = state == ARB_IDLE ? (|pick_set ? ARB_ISSUE : ARB_IDLE)
             : issue ? (!is_exit && !vac ? ARB_IDLE : ARB_CHECK)
             : ARB_IDLE;
  end
  // Parking sees its event during ISSUE; faulty_exit answers during CHECK.
  assign car_entered = issue & !is_exit & vac;
  assign is_uni_car_entered = car_entered & cls;
  assign car_exited = issue & is_exit;
  assign is_uni_car_exited = car_exited & cls;
  assign entry_reject = {2{issue & !is_exit & !vac}} & sel[1:0];
  assign entry_ack = {2{check & !is_exit}} & sel[1:0];
  assign exit_ack = {2{check & is_exit & !faulty_exit}} & sel[3:2];
  assign exit_reject = {2{check & is_exit & faulty_exit}} & sel[3:2];
  assign load = {exit_ack, entry_ack};
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_timer
    gate_timer #(.OPEN_CYCLES(OPEN_CYCLES)) u_timer (
      .clock(clock),
      .reset(reset),
      .load(load[i]),
      .open(gate_open[i])
    );
  end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: table vectors plus rotation/reset sequences, results checked through an expectation queue
module tb_parking_gate_arbiter;
  logic clock = 1'b0, reset = 1'b0;
  logic [1:0] entry_req = '0, entry_is_uni = '0, exit_req = '0, exit_is_uni = '0;
  logic [1:0] entry_ack, entry_reject, exit_ack, exit_reject;
  logic [3:0] gate_open;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic uni_vac = 1'b0, free_vac = 1'b0, faulty = 1'b0;
  logic [15:0] outs;

  parking_gate_arbiter #(.OPEN_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .entry_req(entry_req), .entry_is_uni(entry_is_uni),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni),
    .entry_ack(entry_ack), .entry_reject(entry_reject),
    .exit_ack(exit_ack), .exit_reject(exit_reject),
    .gate_open(gate_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .uni_is_vacated_space(uni_vac), .free_is_vacated_space(free_vac),
    .faulty_exit(faulty)
  );

  assign outs = {entry_ack, entry_reject, exit_ack, exit_reject, gate_open,
                 car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {logic [1:0] lane; logic cls, acc, pulse; int drv;} exp_t;
  typedef struct {logic [1:0] lane; logic cls, vu, vf, faulty, flip, acc, pulse;} vec_t;

  exp_t exp_q[$];
  int pc_q[$];
  int n_chk = 0, n_fail = 0, n_res = 0;

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic [7:0] res;
    exp_t e;
    if (reset) begin
      if (car_entered | car_exited) begin
        chk("pulse_exclusive", int'(car_entered & car_exited), 0);
        pc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("pulse_queue", exp_q.size(), 1);
        else begin
          chk("pulse_class", int'(car_entered ? is_uni_car_entered : is_uni_car_exited), int'(exp_q[0].cls));
          chk("pulse_dir", int'(car_exited), int'(exp_q[0].lane[1]));
          chk("pulse_allowed", 1, int'(exp_q[0].pulse));
        end
      end
      res = {exit_reject, entry_reject, exit_ack, entry_ack};
      if (res != 0) begin
        n_res++;
        if (exp_q.size() == 0) chk("result_queue", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("result_lane", int'(res), e.acc ? (1 << e.lane) : (16 << e.lane));
          if (e.drv >= 0) chk("result_latency", cyc - e.drv, e.pulse ? 2 : 1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_res(int target, int budget);
    for (int i = 0; i < budget && n_res < target; i++) step();
    chk("result_count", n_res, target);
  endtask

  task automatic run_vec(vec_t v);
    int tgt, g;
    uni_vac = v.vu;
    free_vac = v.vf;
    faulty = v.faulty;
    if (v.lane[1]) begin
      exit_is_uni[v.lane[0]] = v.cls;
      exit_req[v.lane[0]] = 1'b1;
    end else begin
      entry_is_uni[v.lane[0]] = v.cls;
      entry_req[v.lane[0]] = 1'b1;
    end
    exp_q.push_back('{v.lane, v.cls, v.acc, v.pulse, cyc});
    tgt = n_res + 1;
    if (v.flip) begin
      step();
      entry_is_uni = ~entry_is_uni;
      exit_is_uni = ~exit_is_uni;
    end
    wait_res(tgt, 10);
    entry_req = '0;
    exit_req = '0;
    g = 0;
    repeat (8) begin
      step();
      g += int'(gate_open[v.lane]);
    end
    chk("gate_cycles", g, v.acc ? 4 : 0);
  endtask

  vec_t vecs[9];
  int ord[$];
  int base, saved, tgt;

  initial begin
    // lane, cls, uni_vac, free_vac, faulty, flip, expect accept, expect Parking pulse
    vecs[0] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (3) step();
    chk("reset_outputs", int'(outs), 0);
    reset = 1'b1;
    step();
    chk("idle_outputs", int'(outs), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // all lanes requesting at once from a fresh round-robin pointer
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    entry_is_uni = 2'b01;
    exit_is_uni = 2'b10;
    uni_vac = 1'b1;
    free_vac = 1'b1;
    faulty = 1'b0;
`ifdef EXIT_PRIORITY_EN
    ord = '{2, 3, 0, 1};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    foreach (ord[k]) exp_q.push_back('{2'(ord[k]), ord[k] == 0 || ord[k] == 3, 1'b1, 1'b1, -1});
    pc_q.delete();
    base = n_res;
    entry_req = 2'b11;
    exit_req = 2'b11;
    foreach (ord[k]) begin
      wait_res(base + k + 1, 20);
`ifdef EXIT_PRIORITY_EN
      if (ord[k] >= 2) exit_req[ord[k] - 2] = 1'b0;
`endif
    end
    entry_req = '0;
    exit_req = '0;
    chk("rotation_pulses", pc_q.size(), ord.size());
    for (int i = 1; i < pc_q.size(); i++) chk("pulse_gap", pc_q[i] - pc_q[i-1], 3);
    repeat (10) step();

    // reset during an entry ISSUE while another lane's gate is open
    exp_q.push_back('{2'd3, 1'b1, 1'b1, 1'b1, cyc});
    exit_req[1] = 1'b1;
    wait_res(n_res + 1, 10);
    exit_req = '0;
    entry_is_uni = 2'b00;
    entry_req[1] = 1'b1;
    exp_q.push_back('{2'd1, 1'b0, 1'b1, 1'b1, -1});
    for (int i = 0; i < 5 && !car_entered; i++) step();
    chk("issue_seen", int'(car_entered), 1);
    saved = n_res;
    reset = 1'b0;
    step();
    chk("abort_outputs", int'(outs), 0);
    exp_q.delete();
    entry_req = 2'b11;
    step();
    chk("abort_no_result", n_res, saved);
    reset = 1'b1;
    exp_q.push_back('{2'd0, 1'b0, 1'b1, 1'b1, -1});
    exp_q.push_back('{2'd1, 1'b0, 1'b1, 1'b1, -1});
    tgt = n_res + 2;
    wait_res(tgt, 20);
    entry_req = '0;
    repeat (8) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
